// File: rtl/cache_cmd_exec_pkg.sv
// Shared cache-control definitions: command encodings used by the control-register
// block and by the command executor.
package cache_cmd_exec_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP   = 3'd0,
    CMD_INIT  = 3'd1,
    CMD_CLEAR = 3'd2,
    CMD_WB    = 3'd3
  } cache_cmd_e;

  // Unassigned encodings collapse to nop so a stray register value never starts work.
  function automatic cache_cmd_e decode_cmd(input logic [CMD_W-1:0] raw);
    cache_cmd_e res;
    case (raw)
      CMD_INIT:  res = CMD_INIT;
      CMD_CLEAR: res = CMD_CLEAR;
      CMD_WB:    res = CMD_WB;
      default:   res = CMD_NOP;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cache_cmd_exec_line_cnt.sv
// Line walker for the command executor: visits every (set, way) pair with the way
// index moving fastest, and flags the final line of the array.
module cache_line_cnt #(
  parameter int SET_NUM = 64,
  parameter int WAY_NUM = 4,
  localparam int SET_W = $clog2(SET_NUM),
  localparam int WAY_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             clear,
  input  logic             inc,
  output logic [SET_W-1:0] set_idx,
  output logic [WAY_W-1:0] way_idx,
  output logic             last
);

  localparam logic [SET_W-1:0] SET_MAX = SET_W'(SET_NUM - 1);
  localparam logic [WAY_W-1:0] WAY_MAX = WAY_W'(WAY_NUM - 1);

  logic way_last;

  assign way_last = (way_idx == WAY_MAX);
  assign last     = way_last && (set_idx == SET_MAX);

  // Set index wraps naturally past the last line because SET_NUM is a power of two.
  always_ff @(posedge clk) begin
    if (rest || clear) begin
      set_idx <= '0;
      way_idx <= '0;
    end else if (inc) begin
      if (way_last) begin
        way_idx <= '0;
        set_idx <= set_idx + SET_W'(1);
      end else begin
        way_idx <= way_idx + WAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/cache_cmd_exec.sv
// Cache maintenance command executor: walks every tag line for init/clear/wb,
// writing back dirty lines before updating their state.
module cache_cmd_exec #(
  parameter int SET_NUM = 64,
  parameter int WAY_NUM = 4,
  localparam int SET_W = $clog2(SET_NUM),
  localparam int WAY_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
) (
  input  logic             clk,
  input  logic             rest,
  input  logic [2:0]       cmd,
  output logic             cmd_ready,
  output logic             busy,
  output logic [SET_W-1:0] tag_set,
  output logic [WAY_W-1:0] tag_way,
  output logic             tag_rd,
  input  logic             tag_valid_i,
  input  logic             tag_dirty_i,
  output logic             tag_we,
  output logic             tag_valid_o,
  output logic             tag_dirty_o,
  output logic             wb_req,
  input  logic             wb_ack
);

  import cache_cmd_exec_pkg::*;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_W,
    ST_READ,
    ST_CHECK,
    ST_WB,
    ST_UPDATE,
    ST_DONE
  } state_e;

  state_e     state, state_nxt;
  cache_cmd_e cmd_dec, cmd_q;
  logic       valid_q;
  logic       accept;
  logic       cnt_clear, cnt_inc, cnt_last;

  assign cmd_dec = decode_cmd(cmd);

  cache_line_cnt #(
    .SET_NUM (SET_NUM),
    .WAY_NUM (WAY_NUM)
  ) u_line_cnt (
    .clk     (clk),
    .rest    (rest),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .set_idx (tag_set),
    .way_idx (tag_way),
    .last    (cnt_last)
  );

  // The sampled valid bit is kept so a wb command can preserve it in UPDATE.
  always_ff @(posedge clk) begin
    if (rest) begin
      state   <= ST_IDLE;
      cmd_q   <= CMD_NOP;
      valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_q <= cmd_dec;
      end
      if (state == ST_CHECK) begin
        valid_q <= tag_valid_i;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    busy        = 1'b1;
    cmd_ready   = 1'b0;
    tag_rd      = 1'b0;
    tag_we      = 1'b0;
    tag_valid_o = 1'b0;
    tag_dirty_o = 1'b0;
    wb_req      = 1'b0;

    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (cmd_dec != CMD_NOP) begin
          accept    = 1'b1;
          cnt_clear = 1'b1;
          state_nxt = (cmd_dec == CMD_INIT) ? ST_INIT_W : ST_READ;
        end
      end
      ST_INIT_W: begin
        tag_we  = 1'b1;
        cnt_inc = 1'b1;
        if (cnt_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_READ: begin
        tag_rd    = 1'b1;
        state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        state_nxt = (tag_valid_i && tag_dirty_i) ? ST_WB : ST_UPDATE;
      end
      ST_WB: begin
        wb_req = 1'b1;
        if (wb_ack) begin
          state_nxt = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        tag_we      = 1'b1;
        tag_valid_o = (cmd_q == CMD_WB) && valid_q;
        cnt_inc     = 1'b1;
        state_nxt   = cnt_last ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        cmd_ready = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_cmd_exec.sv
// Scoreboard bench for cache_cmd_exec with a behavioural tag-array model and a
// writeback responder; expectations are derived from the line-walk rules.
module tb_cache_cmd_exec;

  import cache_cmd_exec_pkg::*;

  localparam int SET_NUM = 4;
  localparam int WAY_NUM = 2;
  localparam int LINES   = SET_NUM * WAY_NUM;

  logic       clk = 1'b0;
  logic       rest;
  logic [2:0] cmd;
  logic       cmd_ready, busy;
  logic [1:0] tag_set;
  logic [0:0] tag_way;
  logic       tag_rd, tag_valid_i, tag_dirty_i;
  logic       tag_we, tag_valid_o, tag_dirty_o;
  logic       wb_req, wb_ack;

  always #5 clk = ~clk;

  cache_cmd_exec #(
    .SET_NUM (SET_NUM),
    .WAY_NUM (WAY_NUM)
  ) dut (
    .clk         (clk),
    .rest        (rest),
    .cmd         (cmd),
    .cmd_ready   (cmd_ready),
    .busy        (busy),
    .tag_set     (tag_set),
    .tag_way     (tag_way),
    .tag_rd      (tag_rd),
    .tag_valid_i (tag_valid_i),
    .tag_dirty_i (tag_dirty_i),
    .tag_we      (tag_we),
    .tag_valid_o (tag_valid_o),
    .tag_dirty_o (tag_dirty_o),
    .wb_req      (wb_req),
    .wb_ack      (wb_ack)
  );

  typedef struct {
    int s;
    int w;
    int v;
    int d;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_wb[$];
  int  exp_done[$];

  bit  mem_v[LINES], mem_d[LINES];
  bit  ref_v[LINES], ref_d[LINES];

  int  checks = 0, errors = 0;
  int  cyc = 0, accept_cyc = 0;
  int  ack_delay = 0, ack_cnt = 0;
  bit  init_running = 1'b0;
  bit  rd_prev = 1'b0, prev_wb = 1'b0;
  int  rd_idx = 0, prev_wb_idx = 0;

  function automatic int line_idx();
    return int'(tag_set) * WAY_NUM + int'(tag_way);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Writeback responder: acknowledges ack_delay cycles after wb_req first appears.
  initial begin
    wb_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rest) begin
        wb_ack  = 1'b0;
        ack_cnt = 0;
      end else if (wb_ack) begin
        wb_ack  = 1'b0;
        ack_cnt = 0;
      end else if (wb_req) begin
        if (ack_cnt >= ack_delay) wb_ack = 1'b1;
        else ack_cnt++;
      end else begin
        ack_cnt = 0;
      end
    end
  end

  // Tag array: read data only valid the cycle after tag_rd, garbage otherwise.
  initial begin
    tag_valid_i = 1'b0;
    tag_dirty_i = 1'b0;
    forever begin
      @(negedge clk);
      if (tag_we && !rest) begin
        mem_v[line_idx()] = tag_valid_o;
        mem_d[line_idx()] = tag_dirty_o;
      end
      tag_valid_i = rd_prev ? mem_v[rd_idx] : 1'($urandom);
      tag_dirty_i = rd_prev ? mem_d[rd_idx] : 1'($urandom);
      rd_prev = tag_rd && !rest;
      rd_idx  = line_idx();
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write, writeback or completion.
  initial begin
    wr_t e;
    int  lat;
    forever begin
      @(negedge clk);
      if (rest) begin
        prev_wb = 1'b0;
      end else begin
        if (tag_rd || tag_we || wb_req)
          checkOutput("one_strobe", int'(tag_rd) + int'(tag_we) + int'(wb_req), 1);
        if (tag_rd)
          checkOutput("rd_during_init", int'(init_running), 0);
        if (tag_we) begin
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wr_unexpected: line %0d written %0d/%0d, expected no write", line_idx(), tag_valid_o, tag_dirty_o);
          end else begin
            e = exp_wr.pop_front();
            checkOutput("wr_set", int'(tag_set), e.s);
            checkOutput("wr_way", int'(tag_way), e.w);
            checkOutput("wr_valid", int'(tag_valid_o), e.v);
            checkOutput("wr_dirty", int'(tag_dirty_o), e.d);
          end
        end
        if (wb_req && !prev_wb) begin
          if (exp_wb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wb_unexpected: wb_req on line %0d, expected none", line_idx());
          end else begin
            checkOutput("wb_line", line_idx(), exp_wb.pop_front());
          end
        end
        if (wb_req && prev_wb)
          checkOutput("wb_hold_line", line_idx(), prev_wb_idx);
        prev_wb     = wb_req;
        prev_wb_idx = line_idx();
        if (cmd_ready) begin
          checkOutput("busy_in_done", int'(busy), 1);
          if (exp_done.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_unexpected: cmd_ready=1, expected 0");
          end else begin
            lat = exp_done.pop_front();
            checkOutput("latency", cyc - accept_cyc + 1, lat);
          end
        end
      end
    end
  end

  task automatic setLine(input int i, input bit v, input bit d);
    mem_v[i] = v;
    mem_d[i] = d;
    ref_v[i] = v;
    ref_d[i] = d;
  endtask

  // Reference model: what a full walk of the array must produce, and how long it takes.
  task automatic buildExpect(input logic [2:0] c, output int lat);
    cache_cmd_e k;
    int nv;
    k   = decode_cmd(c);
    lat = 2;
    for (int i = 0; i < LINES; i++) begin
      if (k == CMD_INIT) begin
        lat += 1;
        nv = 0;
      end else begin
        lat += 3;
        if (ref_v[i] && ref_d[i]) begin
          exp_wb.push_back(i);
          lat += ack_delay + 1;
        end
        nv = (k == CMD_WB) ? int'(ref_v[i]) : 0;
      end
      exp_wr.push_back('{i / WAY_NUM, i % WAY_NUM, nv, 0});
      ref_v[i] = nv[0];
      ref_d[i] = 1'b0;
    end
  endtask

  task automatic flushQueues();
    exp_wr.delete();
    exp_wb.delete();
    exp_done.delete();
  endtask

  task automatic checkArray();
    for (int i = 0; i < LINES; i++) begin
      checkOutput("mem_valid", int'(mem_v[i]), int'(ref_v[i]));
      checkOutput("mem_dirty", int'(mem_d[i]), int'(ref_d[i]));
    end
  endtask

  task automatic checkAllZero();
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_cmd_ready", int'(cmd_ready), 0);
    checkOutput("rst_tag_rd", int'(tag_rd), 0);
    checkOutput("rst_tag_we", int'(tag_we), 0);
    checkOutput("rst_wb_req", int'(wb_req), 0);
    checkOutput("rst_valid_o", int'(tag_valid_o), 0);
    checkOutput("rst_dirty_o", int'(tag_dirty_o), 0);
    checkOutput("rst_tag_set", int'(tag_set), 0);
    checkOutput("rst_tag_way", int'(tag_way), 0);
  endtask

  // Issue one command; scramble drives random cmd values while the DUT is busy.
  task automatic applyStimulus(input logic [2:0] c, input bit scramble);
    int lat;
    bit seen;
    buildExpect(c, lat);
    exp_done.push_back(lat);
    @(negedge clk);
    cmd          = c;
    accept_cyc   = cyc;
    init_running = (decode_cmd(c) == CMD_INIT);
    seen         = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      @(negedge clk);
      if (cmd_ready) seen = 1'b1;
      if (scramble) cmd = seen ? 3'(CMD_NOP) : 3'($urandom);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: no cmd_ready for cmd %0d within 600 cycles", c);
      flushQueues();
    end else if (!scramble) begin
      @(negedge clk);
    end
    cmd = CMD_NOP;
    repeat (3) @(negedge clk);
    init_running = 1'b0;
    checkOutput("busy_after", int'(busy), 0);
    checkOutput("wr_left", exp_wr.size(), 0);
    checkOutput("wb_left", exp_wb.size(), 0);
    checkOutput("done_left", exp_done.size(), 0);
    checkArray();
  endtask

  task automatic resetDuringWb();
    int  lat;
    bit  found;
    for (int i = 0; i < LINES; i++) setLine(i, 1'b1, 1'b0);
    setLine(4, 1'b1, 1'b1);
    ack_delay = 40;
    buildExpect(CMD_WB, lat);
    @(negedge clk);
    cmd   = CMD_WB;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (wb_req && tag_set == 2'd2 && tag_way == 1'b0) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL wb_reach: wb_req for line (2,0) not seen within 200 cycles");
    end
    @(negedge clk);
    rest = 1'b1;
    cmd  = CMD_NOP;
    flushQueues();
    @(negedge clk);
    checkAllZero();
    rest      = 1'b0;
    ack_delay = 0;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_busy", int'(busy), 0);
    applyStimulus(CMD_INIT, 1'b0);
  endtask

  initial begin
    logic [2:0] illegal_vals [4];
    logic [2:0] legal_vals [3];
    bit         v;
    illegal_vals = '{3'd4, 3'd5, 3'd6, 3'd7};
    legal_vals   = '{3'(CMD_INIT), 3'(CMD_CLEAR), 3'(CMD_WB)};

    rest = 1'b1;
    cmd  = CMD_NOP;
    for (int i = 0; i < LINES; i++) setLine(i, 1'($urandom), 1'($urandom));
    repeat (3) @(negedge clk);
    checkAllZero();
    rest = 1'b0;

    $display("[TB] init after reset");
    ack_delay = 0;
    applyStimulus(CMD_INIT, 1'b0);

    $display("[TB] wb with one dirty line (1,1), ack after 3 cycles");
    for (int i = 0; i < LINES; i++) begin
      v = 1'($urandom);
      setLine(i, v, !v && 1'($urandom));
    end
    setLine(3, 1'b1, 1'b1);
    ack_delay = 3;
    applyStimulus(CMD_WB, 1'b0);

    $display("[TB] clear with all lines dirty, immediate ack");
    for (int i = 0; i < LINES; i++) setLine(i, 1'b1, 1'b1);
    ack_delay = 0;
    applyStimulus(CMD_CLEAR, 1'b0);

    $display("[TB] illegal commands ignored");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cmd = illegal_vals[k];
      repeat (2) begin
        @(negedge clk);
        checkOutput("illegal_busy", int'(busy), 0);
      end
    end
    @(negedge clk);
    cmd = CMD_NOP;

    $display("[TB] reset during writeback of line (2,0)");
    resetDuringWb();

    $display("[TB] randomized commands");
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < LINES; i++) setLine(i, 1'($urandom), 1'($urandom));
      ack_delay = $urandom_range(0, 3);
      applyStimulus(legal_vals[$urandom_range(0, 2)], 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
